// File: rtl/tt_sweep_pkg.sv
// -----------------------------------------------------------------------------
// tt_sweep_pkg
// Shared definitions for the truth-table sweep controller:
//   - state_e       : sweep FSM state encoding
//   - settle_cnt_w  : width of the per-vector settle down-counter,
//                     clog2(settle_cycles+1), never less than 1 bit
// -----------------------------------------------------------------------------
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A zero-cycle settle still needs a 1-bit counter so the register exists
  // with a legal width; it is simply never loaded with a non-zero value.
  function automatic int settle_cnt_w(input int settle_cycles);
    int w;
    w = 1;
    while ((1 << w) < (settle_cycles + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tt_expect_ram.sv
// -----------------------------------------------------------------------------
// tt_expect_ram
// Expected-response table for the truth-table sweep: 2^N_IN entries of N_OUT
// bits. Synchronous write, asynchronous (combinational) read, synchronous
// clear of every entry while rst is high.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous, active-high; clears all entries to 0
//   wr_en    in   1      write strobe (already qualified by the caller)
//   wr_addr  in   N_IN   write address
//   wr_data  in   N_OUT  write data
//   rd_addr  in   N_IN   read address
//   rd_data  out  N_OUT  entry at rd_addr, combinational
// -----------------------------------------------------------------------------
module tt_expect_ram #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [N_IN-1:0]  wr_addr,
  input  logic [N_OUT-1:0] wr_data,
  input  logic [N_IN-1:0]  rd_addr,
  output logic [N_OUT-1:0] rd_data
);

  localparam int DEPTH = 1 << N_IN;

  logic [N_OUT-1:0] mem_q [DEPTH];
  logic [N_OUT-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/truth_table_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// truth_table_sweep_ctrl
// Exhaustive self-check sequencer for a combinational netlist with N_IN inputs
// and N_OUT outputs. Drives every input vector 0..2^N_IN-1 in turn, holds each
// for SETTLE_CYCLES extra cycles, then compares the netlist output against a
// locally stored expected table and accumulates the result.
//
// Build option
//   TTSWEEP_ABORT_ON_FAIL_EN  defined   : first mismatch ends the sweep; dut_in
//                                         and first_fail_* hold that vector.
//                             undefined : every vector is always checked.
//
// Ports
//   clk             in   1       rising-edge clock
//   rst             in   1       synchronous, active-high reset
//   start           in   1       request a sweep (sampled only when idle)
//   exp_wr_en       in   1       write expected entry (ignored while busy)
//   exp_wr_addr     in   N_IN    expected-table address (= input vector)
//   exp_wr_data     in   N_OUT   expected netlist output for that vector
//   dut_out         in   N_OUT   netlist outputs (combinational from dut_in)
//   dut_in          out  N_IN    registered vector driven to the netlist
//   busy            out  1       sweep in progress
//   done            out  1       one-cycle pulse at sweep end
//   pass            out  1       last sweep had zero mismatches
//   fail_count      out  N_IN+1  mismatches in the last sweep
//   first_fail_vec  out  N_IN    vector of the first mismatch
//   first_fail_got  out  N_OUT   dut_out captured at the first mismatch
// -----------------------------------------------------------------------------
module truth_table_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int N_OUT         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             exp_wr_en,
  input  logic [N_IN-1:0]  exp_wr_addr,
  input  logic [N_OUT-1:0] exp_wr_data,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    fail_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic [N_OUT-1:0] first_fail_got
);

  localparam int CW     = settle_cnt_w(SETTLE_CYCLES);
  localparam int NVEC   = 1 << N_IN;
  // APPLY lasts SETTLE_CYCLES cycles: load SETTLE_CYCLES-1 and leave on zero.
  localparam int RELOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  localparam logic [N_IN:0] LAST_VEC   = (N_IN + 1)'(NVEC - 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(RELOAD);
  // With no settle time the vector window is the CHECK cycle alone.
  localparam state_e        WORK_STATE = (SETTLE_CYCLES == 0) ? CHECK : APPLY;

  state_e           state_q,    state_d;
  logic [N_IN:0]    vec_q,      vec_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             busy_q,     busy_d;
  logic             pass_q,     pass_d;
  logic [N_IN:0]    fail_cnt_q, fail_cnt_d;
  logic [N_IN-1:0]  ff_vec_q,   ff_vec_d;
  logic [N_OUT-1:0] ff_got_q,   ff_got_d;

  logic             ram_wr_en;
  logic [N_OUT-1:0] exp_rd_data;
  logic             mismatch;
  logic             last_vec;

  // The table is frozen for the whole sweep, including the DONE cycle.
  assign ram_wr_en = exp_wr_en && (state_q == IDLE);

  tt_expect_ram #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_expect_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_wr_en),
    .wr_addr (exp_wr_addr),
    .wr_data (exp_wr_data),
    .rd_addr (vec_q[N_IN-1:0]),
    .rd_data (exp_rd_data)
  );

  assign mismatch = (dut_out != exp_rd_data);
  // Terminal test on the last vector keeps the counter from ever wrapping.
  assign last_vec = (vec_q == LAST_VEC);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    pass_d     = pass_q;
    fail_cnt_d = fail_cnt_q;
    ff_vec_d   = ff_vec_q;
    ff_got_d   = ff_got_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d      = '0;
          cnt_d      = CNT_RELOAD;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          fail_cnt_d = '0;
          ff_vec_d   = '0;
          ff_got_d   = '0;
          state_d    = WORK_STATE;
        end
      end

      APPLY: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      CHECK: begin
        if (mismatch) begin
          fail_cnt_d = fail_cnt_q + (N_IN + 1)'(1);
          if (fail_cnt_q == '0) begin
            ff_vec_d = vec_q[N_IN-1:0];
            ff_got_d = dut_out;
          end
        end
`ifdef TTSWEEP_ABORT_ON_FAIL_EN
        if (mismatch || last_vec) begin
`else
        if (last_vec) begin
`endif
          state_d = DONE;
        end else begin
          vec_d   = vec_q + (N_IN + 1)'(1);
          cnt_d   = CNT_RELOAD;
          state_d = WORK_STATE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        pass_d  = (fail_cnt_q == '0);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      ff_vec_q   <= '0;
      ff_got_q   <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      fail_cnt_q <= fail_cnt_d;
      ff_vec_q   <= ff_vec_d;
      ff_got_q   <= ff_got_d;
    end
  end

  assign dut_in         = vec_q[N_IN-1:0];
  assign busy           = busy_q;
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign fail_count     = fail_cnt_q;
  assign first_fail_vec = ff_vec_q;
  assign first_fail_got = ff_got_q;

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweep_ctrl
// Two controllers share clock and reset: inst A (SETTLE_CYCLES=2) and
// inst B (SETTLE_CYCLES=0). The modelled netlist is out = in for both.
// Each started sweep pushes its expected outcome into a queue; a monitor pops
// one entry per done pulse and compares timing and results.
// -----------------------------------------------------------------------------
module tb_truth_table_sweep_ctrl;

  localparam int N_IN  = 3;
  localparam int N_OUT = 3;
`ifdef TTSWEEP_ABORT_ON_FAIL_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  typedef struct {
    int inst;
    int cyc;
    int pass;
    int fc;
    int ffv;
    int ffg;
    int dutin;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             rst;
  logic             start_a, wen_a, start_b, wen_b;
  logic [N_IN-1:0]  waddr_a, waddr_b;
  logic [N_OUT-1:0] wdata_a, wdata_b;
  logic [N_OUT-1:0] dut_out_a, dut_out_b;
  logic [N_IN-1:0]  dut_in_a, dut_in_b;
  logic             busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [N_IN:0]    fc_a, fc_b;
  logic [N_IN-1:0]  ffv_a, ffv_b;
  logic [N_OUT-1:0] ffg_a, ffg_b;

  assign dut_out_a = dut_in_a;
  assign dut_out_b = dut_in_b;

  truth_table_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .exp_wr_en(wen_a),
    .exp_wr_addr(waddr_a), .exp_wr_data(wdata_a), .dut_out(dut_out_a),
    .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fc_a), .first_fail_vec(ffv_a), .first_fail_got(ffg_a)
  );

  truth_table_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .exp_wr_en(wen_b),
    .exp_wr_addr(waddr_b), .exp_wr_data(wdata_b), .dut_out(dut_out_b),
    .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fc_b), .first_fail_vec(ffv_b), .first_fail_got(ffg_b)
  );

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];
  bit   mon_active = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic push_exp(input int inst, input int c, input int p, input int fc,
                          input int ffv, input int ffg, input int dutin);
    exp_t e;
    e.inst = inst; e.cyc = c; e.pass = p; e.fc = fc;
    e.ffv = ffv; e.ffg = ffg; e.dutin = dutin;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per done pulse; pass/busy checked a cycle later.
  initial begin
    exp_t e;
    int   inst;
    forever begin
      @(negedge clk);
      if (done_a || done_b) begin
        mon_active = 1'b1;
        inst = done_a ? 0 : 1;
        if (sb.size() == 0) begin
          chk("unexpected_done", inst, -1);
        end else begin
          e = sb.pop_front();
          chk("done_inst", inst, e.inst);
          chk("done_cycle", cyc, e.cyc);
          chk("fail_count", inst == 0 ? int'(fc_a)     : int'(fc_b),     e.fc);
          chk("first_vec",  inst == 0 ? int'(ffv_a)    : int'(ffv_b),    e.ffv);
          chk("first_got",  inst == 0 ? int'(ffg_a)    : int'(ffg_b),    e.ffg);
          chk("dut_in_end", inst == 0 ? int'(dut_in_a) : int'(dut_in_b), e.dutin);
          @(negedge clk);
          chk("done_width", inst == 0 ? int'(done_a) : int'(done_b), 0);
          chk("pass",       inst == 0 ? int'(pass_a) : int'(pass_b), e.pass);
          chk("busy_end",   inst == 0 ? int'(busy_a) : int'(busy_b), 0);
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic wr_a(input int a, input int d);
    wen_a = 1'b1; waddr_a = 3'(a); wdata_a = 3'(d);
    @(negedge clk);
    wen_a = 1'b0;
  endtask

  task automatic wr_b(input int a, input int d);
    wen_b = 1'b1; waddr_b = 3'(a); wdata_b = 3'(d);
    @(negedge clk);
    wen_b = 1'b0;
  endtask

  // Start inst A; nchk = vectors checked before DONE; returns edge T.
  task automatic go_a(input bit push, input int nchk, input int p, input int fc,
                      input int ffv, input int ffg, input int dutin, output int t);
    t = cyc + 1;
    if (push) push_exp(0, t + nchk * 3, p, fc, ffv, ffg, dutin);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("busy_start_a", busy_a, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !mon_active) break;
      @(negedge clk);
    end
    chk("sweep_drained", sb.size() + int'(mon_active), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: sweep never completed, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int seen;
    rst = 1'b1;
    start_a = 1'b0; wen_a = 1'b0; waddr_a = '0; wdata_a = '0;
    start_b = 1'b0; wen_b = 1'b0; waddr_b = '0; wdata_b = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    // Reset state
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_fail_count", fc_a, 0);
    chk("rst_dut_in", dut_in_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_dut_in_b", dut_in_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean table: pass
    for (int v = 0; v < 8; v++) wr_a(v, v);
    go_a(1'b1, 8, 1, 0, 0, 0, 7, t);
    drain();

    // Single corrupted entry at vector 5
    wr_a(5, 0);
    go_a(1'b1, ABORT ? 6 : 8, 0, 1, 5, 5, ABORT ? 5 : 7, t);
    drain();

    // Two corrupted entries: 2 and 6
    wr_a(5, 5);
    wr_a(2, 0);
    wr_a(6, 0);
    go_a(1'b1, ABORT ? 3 : 8, 0, ABORT ? 1 : 2, 2, 2, ABORT ? 2 : 7, t);
    drain();

    // start and write while busy are ignored
    wr_a(2, 2);
    wr_a(6, 6);
    go_a(1'b1, 8, 1, 0, 0, 0, 7, t);
    repeat (4) @(negedge clk);
    start_a = 1'b1; wen_a = 1'b1; waddr_a = 3'd4; wdata_a = 3'd0;
    @(negedge clk);
    start_a = 1'b0; wen_a = 1'b0;
    chk("busy_mid_sweep", busy_a, 1);
    drain();
    chk("no_restart_idle", busy_a, 0);

    // Reset mid-sweep: sampled at edge T+10
    go_a(1'b0, 0, 0, 0, 0, 0, 0, t);
    while (cyc < t + 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_pass", pass_a, 0);
    chk("midrst_fail_count", fc_a, 0);
    chk("midrst_first_vec", ffv_a, 0);
    chk("midrst_first_got", ffg_a, 0);
    chk("midrst_dut_in", dut_in_a, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_a) seen++;
      @(negedge clk);
    end
    chk("no_done_after_rst", seen, 0);

    // Reset cleared the table: vectors 1..7 now mismatch
    go_a(1'b1, ABORT ? 2 : 8, 0, ABORT ? 1 : 7, 1, 1, ABORT ? 1 : 7, t);
    drain();

    // Zero settle: one cycle per vector
    for (int v = 0; v < 8; v++) wr_b(v, v);
    t = cyc + 1;
    push_exp(1, t + 8, 1, 0, 0, 0, 7);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("busy_start_b", busy_b, 1);
    chk("b_dut_in_0", dut_in_b, 0);
    @(negedge clk);
    chk("b_dut_in_1", dut_in_b, 1);
    @(negedge clk);
    chk("b_dut_in_2", dut_in_b, 2);
    @(negedge clk);
    chk("b_dut_in_3", dut_in_b, 3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
